rom_fetch_arbiter: RTL and testbench
====================================

Name: rom_fetch_arbiter

Overview:
- Shares the single-port instruction ROM (1 KB, 256 words, registered 1-cycle read, selected via HSEL1/rd_en_rom) between two requesters.
- Port 0 is the core fetch unit; port 1 is the debug/loader read-back path.
- Arbitrates, drives the ROM select/enable/address, and returns the captured instruction word to the winning requester with a fixed latency.
- Sits between the requesters and the ROM on the AHB-side instruction path.

Parameters:
- ROM_BYTES, 1024: ROM size in bytes; byte addresses >= ROM_BYTES are out of range.
- ADDR_W, 32: requester and ROM address width (byte address).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  port 0 read request; held with m0_addr until m0_gnt
- m0_addr  in  ADDR_W  port 0 byte address
- m0_gnt  out  1  port 0 grant pulse (request accepted)
- m0_rvalid  out  1  port 0 read data valid, 1-cycle pulse
- m0_rdata  out  32  port 0 read data
- m0_err  out  1  port 0 error, qualifies m0_rvalid
- m1_req, m1_addr, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as port 0, for port 1
- rom_hsel  out  1  drives ROM HSEL1
- rom_rd_en  out  1  drives ROM rd_en_rom
- rom_addr  out  ADDR_W  drives ROM address_rom (byte address; ROM indexes [9:2])
- rom_rdata  in  32  ROM instruction output

Behaviour:
- FSM states: IDLE, ISSUE, CAPTURE. Reset state is IDLE.
- Reset values: all outputs 0; latched address 0; owner 0; RR pointer = "port 1 last granted".
- IDLE:
  - If any req is high, pick a winner and assert its gnt combinationally in that cycle.
  - Latch the winner's address and owner ID; compute err_flag = (addr[1:0] != 0) or (addr >= ROM_BYTES). Go to ISSUE.
  - With no req, stay in IDLE.
- ISSUE:
  - rom_addr = latched address.
  - rom_hsel = rom_rd_en = !err_flag.
  - Go to CAPTURE unconditionally.
- CAPTURE:
  - Owner's rvalid = 1.
  - Owner's rdata = err_flag ? 0 : rom_rdata.
  - Owner's err = err_flag.
  - Go to IDLE.
- Latency: gnt in cycle T; ROM enabled in T+1; rvalid in T+2. Maximum throughput is 1 read per 3 cycles.
- Erroring requests take the same 3 cycles but never enable the ROM.
- Arbitration (round-robin):
  - A single requester wins.
  - When both request, the port not granted last wins.
  - The pointer updates only on grant.
  - The first grant after reset with both requesting goes to port 0.
- The non-owner's gnt, rvalid and err stay 0. Its rdata is 0 whenever its rvalid is 0.
- Requests arriving in ISSUE or CAPTURE are not granted; they are evaluated in the next IDLE.
- A requester deasserting req before gnt withdraws with no side effect.
- Outside ISSUE: rom_hsel = rom_rd_en = 0 and rom_addr = 0.
- Address boundaries:
  - Byte address ROM_BYTES-4 is valid.
  - ROM_BYTES returns err.
  - Address bits above the range never alias.
- Reset mid-operation (async assert): immediate return to IDLE. All outputs drop to 0 and the in-flight read is discarded; no rvalid is issued. Requesters must re-request.

Optional Feature:
- Macro: ROM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Port 0 always wins when both request; the RR pointer is not implemented; port 1 can starve.
- Undefined: round-robin as above (default).

Test Plan:
- Standard ROM image loaded (word 1 = 32'h00208113, word 2 = 32'h00308193). m0_req with m0_addr=32'h4 in cycle T -> m0_gnt=1 at T; rom_hsel=rom_rd_en=1 and rom_addr=32'h4 at T+1; m0_rvalid=1, m0_rdata=32'h00208113, m0_err=0 at T+2.
- m0 and m1 requesting continuously, m0_addr=32'h4, m1_addr=32'h8 -> grants alternate m0, m1, m0, ... every 3 cycles; m1_rdata=32'h00308193; the other port's rvalid stays 0. With ROM_ARB_FIXED_PRIO_EN defined -> only m0 is granted.
- m1_addr=32'h6 (misaligned), then m1_addr=32'h400 -> each gets m1_rvalid=1, m1_err=1, m1_rdata=0 at T+2; rom_rd_en stays 0 throughout.
- m0_addr=32'h3FC -> m0_err=0, rom_rd_en=1, rom_addr=32'h3FC; data equals word 255 (32'h0).
- reset asserted in the ISSUE cycle of an m0 read -> all outputs 0 in the same cycle; no m0_rvalid afterwards. After release, the next request completes normally in 3 cycles.
- m1_req raised in CAPTURE of an m0 read, then dropped before the next IDLE -> m1_gnt never asserted and no ROM access occurs.

Source files
------------

// File: rtl/rom_fetch_arbiter_if.sv
// Requester and ROM-side signal bundle for rom_fetch_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters/ROM view.
interface rom_fetch_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [31:0]       m0_rdata;
    logic              m0_err;

    logic              m1_req;
    logic [ADDR_W-1:0] m1_addr;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [31:0]       m1_rdata;
    logic              m1_err;

    logic              rom_hsel;
    logic              rom_rd_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_rdata;

    modport slave (
        input  m0_req, m0_addr, m1_req, m1_addr, rom_rdata,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
               m1_gnt, m1_rvalid, m1_rdata, m1_err,
               rom_hsel, rom_rd_en, rom_addr
    );

    modport master (
        output m0_req, m0_addr, m1_req, m1_addr, rom_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
               m1_gnt, m1_rvalid, m1_rdata, m1_err,
               rom_hsel, rom_rd_en, rom_addr
    );
endinterface

// File: rtl/rom_fetch_arbiter.sv
// Two-port arbiter for the single-port instruction ROM: one read per 3 cycles, fixed latency.
// Define ROM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module rom_fetch_arbiter #(
    parameter int ROM_BYTES = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    rom_fetch_arbiter_if.slave   bus
);
    // state   | meaning
    // IDLE    | waiting for a request; grant is combinational here
    // ISSUE   | ROM selected with the latched address (unless the request erred)
    // CAPTURE | ROM word (or error) returned to the owner
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                owner_q, owner_d;
    logic                err_q, err_d;

    logic                win_valid;
    logic                win1;
    logic [ADDR_W-1:0]   win_addr;
    logic                win_err;

    assign win_valid = bus.m0_req | bus.m1_req;
`ifdef ROM_ARB_FIXED_PRIO_EN
    assign win1 = bus.m1_req & ~bus.m0_req;
`else
    logic last_q, last_d;
    // last_q set means port 1 was granted most recently
    assign win1 = bus.m1_req & (~bus.m0_req | ~last_q);
`endif
    assign win_addr = win1 ? bus.m1_addr : bus.m0_addr;
    // Full-width compare so addresses above the ROM never alias into it
    assign win_err  = (win_addr[1:0] != 2'b00) || (win_addr >= ADDR_W'(ROM_BYTES));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        owner_d = owner_q;
        err_d   = err_q;
`ifndef ROM_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = ISSUE;
                    addr_d  = win_addr;
                    owner_d = win1;
                    err_d   = win_err;
`ifndef ROM_ARB_FIXED_PRIO_EN
                    last_d  = win1;
`endif
                end
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
`ifndef ROM_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            owner_q <= owner_d;
            err_q   <= err_d;
`ifndef ROM_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    logic in_idle, in_issue, in_capture;
    assign in_idle    = (state_q == IDLE);
    assign in_issue   = (state_q == ISSUE);
    assign in_capture = (state_q == CAPTURE);

    assign bus.m0_gnt    = in_idle & win_valid & ~win1;
    assign bus.m1_gnt    = in_idle & win_valid &  win1;

    assign bus.rom_hsel  = in_issue & ~err_q;
    assign bus.rom_rd_en = in_issue & ~err_q;
    assign bus.rom_addr  = in_issue ? addr_q : '0;

    // The ROM registers its read, so its output is the word fetched during ISSUE
    assign bus.m0_rvalid = in_capture & ~owner_q;
    assign bus.m1_rvalid = in_capture &  owner_q;
    assign bus.m0_err    = bus.m0_rvalid & err_q;
    assign bus.m1_err    = bus.m1_rvalid & err_q;
    assign bus.m0_rdata  = (bus.m0_rvalid & ~err_q) ? bus.rom_rdata : 32'h0;
    assign bus.m1_rdata  = (bus.m1_rvalid & ~err_q) ? bus.rom_rdata : 32'h0;
endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed, table-driven bench for rom_fetch_arbiter with a behavioural 1-cycle ROM.
module tb_rom_fetch_arbiter;
`ifdef ROM_ARB_FIXED_PRIO_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif
    localparam logic [31:0] W1 = 32'h00208113;
    localparam logic [31:0] W2 = 32'h00308193;

    logic clk;
    logic reset;
    rom_fetch_arbiter_if #(.ADDR_W(32)) bus();

    rom_fetch_arbiter #(.ROM_BYTES(1024), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
        mem[1]   = W1;
        mem[2]   = W2;
        mem[255] = 32'h0;
    end

    initial bus.rom_rdata = 32'h0;
    always @(posedge clk)
        if (bus.rom_hsel && bus.rom_rd_en) bus.rom_rdata <= mem[bus.rom_addr[9:2]];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          r0, r1;
        logic [31:0] a0, a1;
        logic [103:0] exp;
    } vec_t;

    vec_t tbl [26];

    function automatic logic [103:0] mk(bit g0, bit g1, bit v0, bit v1, bit e0, bit e1, bit hs,
                                        logic [31:0] d0, logic [31:0] d1, logic [31:0] ra);
        return {g0, g1, v0, v1, e0, e1, hs, hs, d0, d1, ra};
    endfunction

    function automatic logic [103:0] obs();
        return {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.m0_err, bus.m1_err,
                bus.rom_hsel, bus.rom_rd_en, bus.m0_rdata, bus.m1_rdata, bus.rom_addr};
    endfunction

    task automatic check(input string name, input logic [103:0] exp);
        logic [103:0] act;
        act = obs();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r0, input bit r1, input logic [31:0] a0, input logic [31:0] a1);
        bus.m0_req  = r0;
        bus.m1_req  = r1;
        bus.m0_addr = a0;
        bus.m1_addr = a1;
    endtask

    initial begin
        // r0 r1 a0 a1 : g0 g1 v0 v1 e0 e1 hs d0 d1 ra
        tbl[0]  = '{1, 1, 32'h4, 32'h8, mk(1,0,0,0,0,0,0, 0, 0, 0)};
        tbl[1]  = '{1, 1, 32'h4, 32'h8, mk(0,0,0,0,0,0,1, 0, 0, 32'h4)};
        tbl[2]  = '{1, 1, 32'h4, 32'h8, mk(0,0,1,0,0,0,0, W1, 0, 0)};
        tbl[3]  = '{1, 1, 32'h4, 32'h8, mk(FP,!FP,0,0,0,0,0, 0, 0, 0)};
        tbl[4]  = '{1, 1, 32'h4, 32'h8, mk(0,0,0,0,0,0,1, 0, 0, FP ? 32'h4 : 32'h8)};
        tbl[5]  = '{1, 1, 32'h4, 32'h8, mk(0,0,FP,!FP,0,0,0, FP ? W1 : 32'h0, FP ? 32'h0 : W2, 0)};
        tbl[6]  = '{1, 1, 32'h4, 32'h8, mk(1,0,0,0,0,0,0, 0, 0, 0)};
        tbl[7]  = '{0, 0, 0, 0,         mk(0,0,0,0,0,0,1, 0, 0, 32'h4)};
        tbl[8]  = '{0, 0, 0, 0,         mk(0,0,1,0,0,0,0, W1, 0, 0)};
        tbl[9]  = '{0, 1, 0, 32'h6,     mk(0,1,0,0,0,0,0, 0, 0, 0)};
        tbl[10] = '{0, 0, 0, 0,         mk(0,0,0,0,0,0,0, 0, 0, 32'h6)};
        tbl[11] = '{0, 1, 0, 32'h400,   mk(0,0,0,1,0,1,0, 0, 0, 0)};
        tbl[12] = '{0, 1, 0, 32'h400,   mk(0,1,0,0,0,0,0, 0, 0, 0)};
        tbl[13] = '{0, 0, 0, 0,         mk(0,0,0,0,0,0,0, 0, 0, 32'h400)};
        tbl[14] = '{0, 0, 0, 0,         mk(0,0,0,1,0,1,0, 0, 0, 0)};
        tbl[15] = '{1, 0, 32'h3FC, 0,   mk(1,0,0,0,0,0,0, 0, 0, 0)};
        tbl[16] = '{0, 0, 0, 0,         mk(0,0,0,0,0,0,1, 0, 0, 32'h3FC)};
        tbl[17] = '{0, 1, 0, 32'h8,     mk(0,0,1,0,0,0,0, 32'h0, 0, 0)};
        tbl[18] = '{0, 0, 0, 0,         mk(0,0,0,0,0,0,0, 0, 0, 0)};
        tbl[19] = '{1, 0, 32'h404, 0,   mk(1,0,0,0,0,0,0, 0, 0, 0)};
        tbl[20] = '{0, 0, 0, 0,         mk(0,0,0,0,0,0,0, 0, 0, 32'h404)};
        tbl[21] = '{0, 0, 0, 0,         mk(0,0,1,0,1,0,0, 0, 0, 0)};
        tbl[22] = '{0, 1, 0, 32'hC,     mk(0,1,0,0,0,0,0, 0, 0, 0)};
        tbl[23] = '{1, 0, 32'h10, 0,    mk(0,0,0,0,0,0,1, 0, 0, 32'hC)};
        tbl[24] = '{0, 0, 0, 0,         mk(0,0,0,1,0,0,0, 0, 32'hA500_0003, 0)};
        tbl[25] = '{0, 0, 0, 0,         mk(0,0,0,0,0,0,0, 0, 0, 0)};

        reset = 1'b1;
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("reset_state", '0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].r0, tbl[i].r1, tbl[i].a0, tbl[i].a1);
            @(negedge clk);
            check($sformatf("vec%0d", i), tbl[i].exp);
            @(posedge clk); #1;
        end

        // Async reset during ISSUE discards the in-flight read
        drive(1, 0, 32'h4, 0);
        @(negedge clk);
        check("rst_seq_gnt", mk(1,0,0,0,0,0,0, 0, 0, 0));
        @(posedge clk); #1;
        drive(0, 0, 0, 0);
        check("rst_seq_issue", mk(0,0,0,0,0,0,1, 0, 0, 32'h4));
        reset = 1'b1;
        #1;
        check("rst_seq_async_drop", '0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rst_seq_quiet%0d", i), '0);
        end
        @(posedge clk); #1;
        drive(1, 0, 32'h8, 0);
        @(negedge clk);
        check("post_rst_gnt", mk(1,0,0,0,0,0,0, 0, 0, 0));
        @(posedge clk); #1;
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("post_rst_issue", mk(0,0,0,0,0,0,1, 0, 0, 32'h8));
        @(negedge clk);
        check("post_rst_capture", mk(0,0,1,0,0,0,0, W2, 0, 0));
        @(negedge clk);
        check("post_rst_idle", '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
